// File: rtl/mem_responder.sv
// mem_responder: CVP14 memory-bus responder with a single-port word array,
// programmable read latency and a posted-write buffer that forwards to reads.
module mem_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                        Clk1,
    input  logic                        Reset,
    input  logic [ADDR_W-1:0]           Addr,
    input  logic [DATA_W-1:0]           DataIn,
    input  logic                        RD,
    input  logic                        WR,
    output logic [DATA_W-1:0]           DataOut,
    output logic                        Valid,
    output logic                        Busy,
    output logic [$clog2(WBUF_DEPTH):0] PendWr,
    output logic                        Err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DEPTH_LOG2-1:0] idx;
        logic [DATA_W-1:0]     data;
    } wbuf_entry_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    wbuf_entry_t           wbuf [WBUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  push;
    logic                  rd_acc;
    logic                  rd_claim;
    logic                  drain;
    logic [DATA_W-1:0]     rd_word;

    logic                  pv [RD_LAT];
    logic [DATA_W-1:0]     pd [RD_LAT];

    logic                  unused_addr_hi;

    // Upper address bits alias modulo depth.
    assign req_idx        = Addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^Addr[ADDR_W-1:DEPTH_LOG2];

    assign Busy     = (count == CNT_W'(WBUF_DEPTH));
    assign push     = WR && !Busy;
    assign rd_acc   = RD && !WR && !Busy;
    // An accepted RD, even one demoted to a write, holds the array port.
    assign rd_claim = RD && !Busy;
    assign drain    = (count != '0) && !rd_claim;

    // Youngest matching buffer entry wins over the array.
    always_comb begin
        rd_word = mem[req_idx];
        for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (wbuf[head + PTR_W'(k)].idx == req_idx)) begin
                rd_word = wbuf[head + PTR_W'(k)].data;
            end
        end
    end

    // Storage without reset: array contents survive reset.
    always_ff @(posedge Clk1) begin
        if (push) begin
            wbuf[tail] <= '{idx: req_idx, data: DataIn};
        end
        if (drain && Reset) begin
            mem[wbuf[head].idx] <= wbuf[head].data;
        end
    end

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            if (push && !drain) begin
                count <= count + CNT_W'(1);
            end else if (!push && drain) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Read pipeline; data stages hold their value between responses.
    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) begin
                pd[0] <= rd_word;
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            Err <= 1'b0;
        end else if (RD && WR) begin
            Err <= 1'b1;
        end
    end

    assign Valid   = pv[RD_LAT-1];
    assign DataOut = pd[RD_LAT-1];
    assign PendWr  = count;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench; read expectations are queued at issue
// time with their due cycle and popped when the response cycle arrives.
module tb_mem_responder;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
    } op_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [15:0] din;
    logic        rd;
    logic        wr;
    logic [15:0] dout2, dout3;
    logic        valid2, valid3, busy2, busy3, err2, err3;
    logic [2:0]  pend2, pend3;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q2 [$];
    exp_t        q3 [$];
    logic [15:0] model [1024];

    mem_responder #(.RD_LAT(2)) dut (
        .Clk1(clk), .Reset(reset_n), .Addr(addr), .DataIn(din), .RD(rd), .WR(wr),
        .DataOut(dout2), .Valid(valid2), .Busy(busy2), .PendWr(pend2), .Err(err2)
    );

    mem_responder #(.RD_LAT(3)) dut3 (
        .Clk1(clk), .Reset(reset_n), .Addr(addr), .DataIn(din), .RD(rd), .WR(wr),
        .DataOut(dout3), .Valid(valid3), .Busy(busy3), .PendWr(pend3), .Err(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        return op_t'({r, w, a, d});
    endfunction

    // Request driven now is accepted at the next edge (cyc+1); a response is
    // visible RD_LAT-1 edges after that, i.e. when cyc == now + RD_LAT.
    task automatic issue(input op_t op);
        rd   = op.r;
        wr   = op.w;
        addr = op.a;
        din  = op.d;
        if (op.w) begin
            model[op.a[9:0]] = op.d;
        end else if (op.r) begin
            q2.push_back('{data: model[op.a[9:0]], due: cyc + 2});
            q3.push_back('{data: model[op.a[9:0]], due: cyc + 3});
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        issue(op_t'(0));
        step();
        step();
        checks++; if (dout2 !== 16'h0000) begin failures++; $display("FAIL reset_dataout got=%h required=%h", dout2, 16'h0000); end
        checks++; if (valid2 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", valid2); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy2); end
        checks++; if (pend2 !== 3'd0) begin failures++; $display("FAIL reset_pendwr got=%0d required=0", pend2); end
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err2); end
        checks++; if (valid3 !== 1'b0 || dout3 !== 16'h0000) begin failures++; $display("FAIL reset_lat3 got valid=%b data=%h required valid=0 data=0000", valid3, dout3); end
        reset_n = 1'b1;
    endtask

    task automatic test_read_latency();
        op_t  ops [$];
        exp_t e = '{data: 16'h0, due: 0};
        bit   exp_v;
        ops.push_back(mk(1'b0, 1'b1, 16'h0010, 16'h1234));
        ops.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000));
        ops.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000));
        for (int i = 0; i < ops.size() + 5; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v) e = q2.pop_front();
            checks++;
            if ((valid2 !== exp_v) || (exp_v && (dout2 !== e.data))) begin
                failures++;
                $display("FAIL lat_resp cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v, e.data);
            end
            if (i == 1) begin
                checks++; if (pend2 !== 3'd0) begin failures++; $display("FAIL lat_preload_pend got=%0d required=0", pend2); end
            end
        end
        checks++;
        if (dout2 !== 16'h1234 || valid2 !== 1'b0) begin
            failures++;
            $display("FAIL lat_hold got valid=%b data=%h required valid=0 data=1234", valid2, dout2);
        end
    endtask

    task automatic test_forwarding();
        op_t  ops [$];
        exp_t e = '{data: 16'h0, due: 0};
        bit   exp_v;
        int   exp_pend [3] = '{1, 1, 0};
        ops.push_back(mk(1'b0, 1'b1, 16'h0020, 16'hBEEF));
        ops.push_back(mk(1'b1, 1'b0, 16'h0020, 16'h0000));
        ops.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000));
        ops.push_back(mk(1'b1, 1'b0, 16'h0020, 16'h0000));
        for (int i = 0; i < ops.size() + 4; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v) e = q2.pop_front();
            checks++;
            if ((valid2 !== exp_v) || (exp_v && (dout2 !== e.data))) begin
                failures++;
                $display("FAIL fwd_resp cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v, e.data);
            end
            if (i < 3) begin
                checks++;
                if (pend2 !== 3'(exp_pend[i])) begin failures++; $display("FAIL fwd_pend step=%0d got=%0d required=%0d", i, pend2, exp_pend[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t  ops [$];
        exp_t e2 = '{data: 16'h0, due: 0};
        exp_t e3 = '{data: 16'h0, due: 0};
        bit   exp_v2, exp_v3;
        int   nvalid3 = 0;
        q3.delete();
        for (int k = 0; k < 8; k++) ops.push_back(mk(1'b0, 1'b1, 16'(k), 16'hA500 + 16'(k)));
        ops.push_back(op_t'(0));
        ops.push_back(op_t'(0));
        for (int k = 0; k < 8; k++) ops.push_back(mk(1'b1, 1'b0, 16'(k), 16'h0000));
        for (int i = 0; i < ops.size() + 5; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v2 = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v2) e2 = q2.pop_front();
            exp_v3 = (q3.size() > 0) && (q3[0].due == cyc);
            if (exp_v3) e3 = q3.pop_front();
            if (valid3 === 1'b1) nvalid3++;
            checks++;
            if ((valid2 !== exp_v2) || (exp_v2 && (dout2 !== e2.data))) begin
                failures++;
                $display("FAIL b2b_lat2_resp cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v2, e2.data);
            end
            checks++;
            if ((valid3 !== exp_v3) || (exp_v3 && (dout3 !== e3.data))) begin
                failures++;
                $display("FAIL b2b_lat3_resp cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid3, dout3, exp_v3, e3.data);
            end
            if (i == 9) begin
                checks++; if (pend2 !== 3'd0) begin failures++; $display("FAIL b2b_drained got=%0d required=0", pend2); end
            end
        end
        checks++;
        if (nvalid3 != 8) begin failures++; $display("FAIL b2b_valid_count got=%0d required=8", nvalid3); end
    endtask

    task automatic test_err();
        op_t  ops [$];
        exp_t e = '{data: 16'h0, due: 0};
        bit   exp_v;
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL err_clear got=%b required=0", err2); end
        ops.push_back(mk(1'b1, 1'b1, 16'h0005, 16'h00AA));
        ops.push_back(op_t'(0));
        ops.push_back(op_t'(0));
        ops.push_back(mk(1'b1, 1'b0, 16'h0005, 16'h0000));
        for (int i = 0; i < ops.size() + 4; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v) e = q2.pop_front();
            checks++;
            if ((valid2 !== exp_v) || (exp_v && (dout2 !== e.data))) begin
                failures++;
                $display("FAIL err_resp cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v, e.data);
            end
            if (i == 0) begin
                checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL err_set got=%b required=1", err2); end
            end
            if (i == 1) begin
                checks++; if (pend2 !== 3'd0) begin failures++; $display("FAIL err_drain got=%0d required=0", pend2); end
            end
        end
        checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b required=1", err2); end
    endtask

    task automatic test_alias();
        op_t  ops [$];
        exp_t e = '{data: 16'h0, due: 0};
        bit   exp_v;
        int   exp_pend [5] = '{1, 2, 2, 1, 0};
        // RD held with WR keeps both same-index writes buffered together.
        ops.push_back(mk(1'b1, 1'b1, 16'h0400, 16'h0001));
        ops.push_back(mk(1'b1, 1'b1, 16'h0000, 16'h0002));
        ops.push_back(mk(1'b1, 1'b0, 16'h0400, 16'h0000));
        ops.push_back(op_t'(0));
        ops.push_back(op_t'(0));
        ops.push_back(op_t'(0));
        ops.push_back(mk(1'b1, 1'b0, 16'h0400, 16'h0000));
        ops.push_back(mk(1'b1, 1'b0, 16'h0000, 16'h0000));
        for (int i = 0; i < ops.size() + 4; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v) e = q2.pop_front();
            checks++;
            if ((valid2 !== exp_v) || (exp_v && (dout2 !== e.data))) begin
                failures++;
                $display("FAIL alias_resp cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v, e.data);
            end
            if (i < 5) begin
                checks++;
                if (pend2 !== 3'(exp_pend[i])) begin failures++; $display("FAIL alias_pend step=%0d got=%0d required=%0d", i, pend2, exp_pend[i]); end
            end
        end
    endtask

    task automatic test_full();
        op_t  ops [$];
        exp_t e = '{data: 16'h0, due: 0};
        bit   exp_v;
        int   widx      [6] = '{0, 1, 2, 3, 4, 4};
        bit   exp_busy  [6] = '{0, 0, 0, 0, 1, 0};
        int   exp_pend  [6] = '{1, 2, 3, 4, 3, 4};
        int   idle_pend [4] = '{3, 2, 1, 0};
        for (int j = 0; j < 6; j++) begin
            issue(mk(1'b1, 1'b1, 16'h0100 + 16'(widx[j]), 16'hC000 + 16'(widx[j])));
            checks++;
            if (busy2 !== exp_busy[j]) begin failures++; $display("FAIL full_busy req=%0d got=%b required=%b", j, busy2, exp_busy[j]); end
            step();
            checks++;
            if (pend2 !== 3'(exp_pend[j])) begin failures++; $display("FAIL full_pend req=%0d got=%0d required=%0d", j, pend2, exp_pend[j]); end
        end
        for (int j = 0; j < 4; j++) begin
            issue(op_t'(0));
            step();
            checks++;
            if (pend2 !== 3'(idle_pend[j])) begin failures++; $display("FAIL full_drain step=%0d got=%0d required=%0d", j, pend2, idle_pend[j]); end
        end
        for (int k = 0; k < 5; k++) ops.push_back(mk(1'b1, 1'b0, 16'h0100 + 16'(k), 16'h0000));
        for (int i = 0; i < ops.size() + 3; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v) e = q2.pop_front();
            checks++;
            if ((valid2 !== exp_v) || (exp_v && (dout2 !== e.data))) begin
                failures++;
                $display("FAIL full_readback cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v, e.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        op_t  ops [$];
        exp_t e = '{data: 16'h0, due: 0};
        bit   exp_v;
        // Writes to address 5 that reset must discard; not entered in the model.
        rd = 1'b1; wr = 1'b1; addr = 16'h0005; din = 16'h5555;
        step();
        din = 16'h6666;
        step();
        rd = 1'b1; wr = 1'b0; addr = 16'h0010; din = 16'h0000;
        step();
        checks++; if (pend2 !== 3'd2) begin failures++; $display("FAIL rstmid_pending got=%0d required=2", pend2); end
        reset_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 16'h0000;
        step();
        reset_n = 1'b1;
        checks++; if (pend2 !== 3'd0) begin failures++; $display("FAIL rstmid_pendwr got=%0d required=0", pend2); end
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b required=0", err2); end
        checks++; if (dout2 !== 16'h0000) begin failures++; $display("FAIL rstmid_dataout got=%h required=0000", dout2); end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (valid2 !== 1'b0 || valid3 !== 1'b0) begin failures++; $display("FAIL rstmid_flush step=%0d got valid2=%b valid3=%b required 0", j, valid2, valid3); end
            step();
        end
        ops.push_back(mk(1'b1, 1'b0, 16'h0005, 16'h0000));
        ops.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000));
        for (int i = 0; i < ops.size() + 3; i++) begin
            issue(i < ops.size() ? ops[i] : op_t'(0));
            step();
            exp_v = (q2.size() > 0) && (q2[0].due == cyc);
            if (exp_v) e = q2.pop_front();
            checks++;
            if ((valid2 !== exp_v) || (exp_v && (dout2 !== e.data))) begin
                failures++;
                $display("FAIL rstmid_array cyc=%0d got valid=%b data=%h required valid=%b data=%h", cyc, valid2, dout2, exp_v, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_forwarding();
        test_back_to_back();
        test_err();
        test_alias();
        test_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
